// File: rtl/wei_instr_arbiter.sv
// Round-robin arbiter feeding the weight-address instruction port; counts one filter group of instructions.
// Optional WEI_ARB_PERF_EN adds stall/idle performance counters.
module wei_instr_arbiter #(
    parameter int unsigned NUM_PEB     = 16,
    parameter int unsigned INSTR_WIDTH = 8,
    parameter int unsigned CNT_WIDTH   = 12
) (
    input  logic                           clk,
    input  logic                           rst,
`ifdef WEI_ARB_PERF_EN
    output logic [15:0]                    perf_stall_cnt_o,
    output logic [15:0]                    perf_idle_cnt_o,
`endif
    input  logic                           start_i,
    input  logic                           abort_i,
    input  logic [NUM_PEB-1:0]             cfg_peb_mask_i,
    input  logic [CNT_WIDTH-1:0]           cfg_instr_total_i,
    output logic                           busy_o,
    output logic                           done_o,
    input  logic [NUM_PEB-1:0]             req_val_i,
    output logic [NUM_PEB-1:0]             req_rdy_o,
    input  logic [NUM_PEB*INSTR_WIDTH-1:0] req_data_i,
    output logic                           out_val_o,
    input  logic                           out_rdy_i,
    output logic [3:0]                     out_peb_o,
    output logic [INSTR_WIDTH-1:0]         out_data_o
);

    localparam int unsigned PEB_W  = 4;
    localparam int unsigned PERF_W = 16;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

    state_e                 state_q, state_d;
    logic [PEB_W-1:0]       ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]   grant_cnt_q, grant_cnt_d;
    logic [CNT_WIDTH-1:0]   acc_cnt_q, acc_cnt_d;
    logic [NUM_PEB-1:0]     mask_q, mask_d;
    logic [CNT_WIDTH-1:0]   total_q, total_d;
    logic                   out_val_q, out_val_d;
    logic [PEB_W-1:0]       out_peb_q, out_peb_d;
    logic [INSTR_WIDTH-1:0] out_data_q, out_data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
`ifdef WEI_ARB_PERF_EN
    logic [PERF_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0]      idle_cnt_q, idle_cnt_d;
`endif

    logic                   found_c;
    logic [PEB_W-1:0]       gidx_c;
    logic                   grant_c;
    logic                   xfer_c;

    // Round-robin search starting at ptr_q over masked, valid requesters
    always_comb begin
        int unsigned idx;
        found_c = 1'b0;
        gidx_c  = '0;
        idx     = 0;
        for (int k = 0; k < int'(NUM_PEB); k++) begin
            idx = (int'(ptr_q) + k) % NUM_PEB;
            if (!found_c && req_val_i[idx] && mask_q[idx]) begin
                found_c = 1'b1;
                gidx_c  = PEB_W'(idx);
            end
        end
    end

    assign grant_c = (state_q == S_RUN) && (grant_cnt_q < total_q) && !abort_i
                     && (!out_val_q || out_rdy_i) && found_c;
    assign xfer_c  = out_val_q && out_rdy_i;

    always_comb begin
        req_rdy_o = '0;
        if (grant_c) req_rdy_o[gidx_c] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_cnt_d = grant_cnt_q;
        acc_cnt_d   = acc_cnt_q;
        mask_d      = mask_q;
        total_d     = total_q;
        out_val_d   = out_val_q;
        out_peb_d   = out_peb_q;
        out_data_d  = out_data_q;
`ifdef WEI_ARB_PERF_EN
        stall_cnt_d = stall_cnt_q;
        idle_cnt_d  = idle_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mask_d      = cfg_peb_mask_i;
                    total_d     = cfg_instr_total_i;
                    grant_cnt_d = '0;
                    acc_cnt_d   = '0;
                    ptr_d       = '0;
                    state_d     = S_RUN;
`ifdef WEI_ARB_PERF_EN
                    stall_cnt_d = '0;
                    idle_cnt_d  = '0;
`endif
                end
            end
            S_RUN: begin
`ifdef WEI_ARB_PERF_EN
                if (out_val_q && !out_rdy_i && stall_cnt_q != '1)
                    stall_cnt_d = stall_cnt_q + PERF_W'(1);
                if (!out_val_q && !grant_c && idle_cnt_q != '1)
                    idle_cnt_d = idle_cnt_q + PERF_W'(1);
`endif
                if (abort_i) begin
                    state_d   = S_IDLE;
                    out_val_d = 1'b0;
                end else begin
                    if (xfer_c) begin
                        acc_cnt_d = acc_cnt_q + CNT_WIDTH'(1);
                        out_val_d = 1'b0;
                        if (acc_cnt_d == total_q) state_d = S_FIN;
                    end
                    if (total_q == '0) state_d = S_FIN;
                    // A grant reloads the slot, overriding the clear from a same-edge transfer
                    if (grant_c) begin
                        out_val_d   = 1'b1;
                        out_peb_d   = gidx_c;
                        out_data_d  = req_data_i[int'(gidx_c)*INSTR_WIDTH +: INSTR_WIDTH];
                        grant_cnt_d = grant_cnt_q + CNT_WIDTH'(1);
                        ptr_d       = (gidx_c == PEB_W'(NUM_PEB - 1)) ? '0 : gidx_c + PEB_W'(1);
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            grant_cnt_q <= '0;
            acc_cnt_q   <= '0;
            mask_q      <= '0;
            total_q     <= '0;
            out_val_q   <= 1'b0;
            out_peb_q   <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef WEI_ARB_PERF_EN
            stall_cnt_q <= '0;
            idle_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_cnt_q <= grant_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
            mask_q      <= mask_d;
            total_q     <= total_d;
            out_val_q   <= out_val_d;
            out_peb_q   <= out_peb_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef WEI_ARB_PERF_EN
            stall_cnt_q <= stall_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
`endif
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign out_val_o  = out_val_q;
    assign out_peb_o  = out_peb_q;
    assign out_data_o = out_data_q;
`ifdef WEI_ARB_PERF_EN
    assign perf_stall_cnt_o = stall_cnt_q;
    assign perf_idle_cnt_o  = idle_cnt_q;
`endif

endmodule
